multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle RV32I core variant: drives one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction.
- Sits in the controller next to the opcode-level decode and the alu_decoder. Takes the latched IR opcode, the branch-unit result and the memory handshake.
- Issues per-cycle datapath strobes and mux selects, and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: drives shared ALU, unified memory port and
// register-file strobes, trapping on illegal opcodes or memory timeouts.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALUWB     = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13,
    S_UPPER     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TO_LIMIT = (CW+1)'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic          trap_q, trap_d;
  logic [1:0]    trap_cause_q, trap_cause_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW:0]   wait_inc;
  logic          mem_wait;
  logic          timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE:        imm_src = 3'b001;
      OP_BRANCH:       imm_src = 3'b010;
      OP_JAL:          imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:         imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    trap_d        = trap_q;
    trap_cause_d  = trap_cause_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 2'b00;
    instr_retired = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d      = S_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        result_src    = 2'b10;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_UPPER: begin
        alu_src_a     = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b     = 2'b01;
        result_src    = 2'b10;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Timeout fires on the wait cycle that brings the count to the limit;
    // any state change (including the trap itself) clears the counter.
    mem_wait    = mem_req && !mem_ready;
    wait_inc    = {1'b0, wait_cnt_q} + (CW+1)'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && mem_wait && (wait_inc == TO_LIMIT);
    if (timeout_hit) begin
      state_d      = S_TRAP;
      trap_d       = 1'b1;
      trap_cause_d = 2'b10;
    end
    wait_cnt_d = (mem_wait && (TIMEOUT_CYCLES != 0) && (state_d == state_q)) ? wait_inc[CW-1:0] : '0;
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction phase-plan model checked every
// cycle against two instances (timeout disabled and TIMEOUT_CYCLES=4).
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic       d0_mem_req, d0_mem_write, d0_adr_src, d0_ir_write, d0_pc_write, d0_reg_write;
  logic [1:0] d0_alu_src_a, d0_alu_src_b, d0_result_src, d0_alu_op, d0_trap_cause;
  logic [2:0] d0_imm_src;
  logic       d0_instr_retired, d0_trap;
  logic [3:0] d0_state;
  logic       d1_mem_req, d1_mem_write, d1_adr_src, d1_ir_write, d1_pc_write, d1_reg_write;
  logic [1:0] d1_alu_src_a, d1_alu_src_b, d1_result_src, d1_alu_op, d1_trap_cause;
  logic [2:0] d1_imm_src;
  logic       d1_instr_retired, d1_trap;
  logic [3:0] d1_state;

  multicycle_controller dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(d0_mem_req), .mem_write(d0_mem_write), .adr_src(d0_adr_src), .ir_write(d0_ir_write),
    .pc_write(d0_pc_write), .reg_write(d0_reg_write), .alu_src_a(d0_alu_src_a),
    .alu_src_b(d0_alu_src_b), .result_src(d0_result_src), .imm_src(d0_imm_src),
    .alu_op(d0_alu_op), .instr_retired(d0_instr_retired), .trap(d0_trap),
    .trap_cause(d0_trap_cause), .state(d0_state)
  );

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(d1_mem_req), .mem_write(d1_mem_write), .adr_src(d1_adr_src), .ir_write(d1_ir_write),
    .pc_write(d1_pc_write), .reg_write(d1_reg_write), .alu_src_a(d1_alu_src_a),
    .alu_src_b(d1_alu_src_b), .result_src(d1_result_src), .imm_src(d1_imm_src),
    .alu_op(d1_alu_op), .instr_retired(d1_instr_retired), .trap(d1_trap),
    .trap_cause(d1_trap_cause), .state(d1_state)
  );

  // Packed view: [24]mem_req [23]mem_write [22]adr_src [21]ir_write [20]pc_write
  // [19]reg_write [18:17]a [16:15]b [14:13]result [12:11]alu_op [10]retired
  // [9:7]imm [6]trap [5:4]cause [3:0]state
  logic [24:0] pk0, pk1, s;
  assign pk0 = {d0_mem_req, d0_mem_write, d0_adr_src, d0_ir_write, d0_pc_write, d0_reg_write,
                d0_alu_src_a, d0_alu_src_b, d0_result_src, d0_alu_op, d0_instr_retired,
                d0_imm_src, d0_trap, d0_trap_cause, d0_state};
  assign pk1 = {d1_mem_req, d1_mem_write, d1_adr_src, d1_ir_write, d1_pc_write, d1_reg_write,
                d1_alu_src_a, d1_alu_src_b, d1_result_src, d1_alu_op, d1_instr_retired,
                d1_imm_src, d1_trap, d1_trap_cause, d1_state};

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          sel = 0;
  int          m_state, m_waits, m_stall, m_base, dut_gap;
  int          m_plan[$];
  logic        m_trap;
  logic [1:0]  m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'b001;
      OP_BRANCH:        return 3'b010;
      OP_JAL:           return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic int base_of(input logic [6:0] op);
    case (op)
      OP_LOAD:                 return 5;
      OP_BRANCH, OP_LUI, OP_AUIPC: return 3;
      default:                 return 4;
    endcase
  endfunction

  // Remaining states of an instruction after its fetch completes.
  task automatic plan_for(input logic [6:0] op);
    case (op)
      OP_LOAD:          m_plan = {2, 3, 4, 5};
      OP_STORE:         m_plan = {2, 3, 6};
      OP_R:             m_plan = {2, 7, 9};
      OP_I:             m_plan = {2, 8, 9};
      OP_BRANCH:        m_plan = {2, 10};
      OP_JAL:           m_plan = {2, 11, 9};
      OP_JALR:          m_plan = {2, 12, 13};
      OP_LUI, OP_AUIPC: m_plan = {2, 14};
      default:          m_plan = {2, 15};
    endcase
  endtask

  function automatic logic [24:0] expect_vec(input logic rdy, input logic bt);
    logic mr, mw, as, iw, pw, rw, ret;
    logic [1:0] a, b, rs, ao;
    {mr, mw, as, iw, pw, rw, ret} = '0;
    {a, b, rs, ao} = '0;
    case (m_state)
      1:  begin mr = 1; b = 2; rs = 2; iw = rdy; pw = rdy; end
      2:  begin a = 1; b = 1; end
      3:  begin a = 2; b = 1; end
      4:  begin mr = 1; as = 1; end
      5:  begin rs = 1; rw = 1; ret = 1; end
      6:  begin mr = 1; mw = 1; as = 1; ret = rdy; end
      7:  begin a = 2; ao = 2; end
      8:  begin a = 2; b = 1; ao = 2; end
      9:  begin rw = 1; ret = 1; end
      10: begin a = 2; ao = 1; pw = bt; ret = 1; end
      11: begin a = 1; b = 2; pw = 1; end
      12: begin a = 2; b = 1; rs = 2; pw = 1; end
      13: begin a = 1; b = 2; rs = 2; rw = 1; ret = 1; end
      14: begin a = (opcode == OP_LUI) ? 2'd3 : 2'd1; b = 1; rs = 2; rw = 1; ret = 1; end
      default: ;
    endcase
    return {mr, mw, as, iw, pw, rw, a, b, rs, ao, ret, imm_of(opcode), m_trap, m_cause, 4'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_waits = 0; m_stall = 0; m_base = 0; dut_gap = 0;
    m_plan = {}; m_trap = 1'b0; m_cause = 2'b00;
  endtask

  task automatic model_advance(input logic rdy);
    int to_lim;
    to_lim = (sel != 0) ? 4 : 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0:  m_state = 1;
      15: ;
      default: begin
        if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
          m_waits++;
          m_stall++;
          if (to_lim != 0 && m_waits == to_lim) begin
            m_state = 15; m_trap = 1'b1; m_cause = 2'b10;
          end
        end else begin
          m_waits = 0;
          if (m_state == 1) begin
            plan_for(opcode);
            m_base = base_of(opcode);
          end
          if (m_plan.size() == 0) begin
            m_state = 1;
            m_stall = 0;
          end else begin
            m_state = m_plan.pop_front();
            if (m_state == 15) begin
              m_trap = 1'b1; m_cause = 2'b01;
            end
          end
        end
      end
    endcase
  endtask

  // One clock cycle: drive, sample 1ns later, compare, advance model, wait for next negedge.
  task automatic tick(input logic rdy, input logic bt);
    mem_ready = rdy;
    branch_taken = bt;
    #1;
    s = (sel != 0) ? pk1 : pk0;
    check("cycle_outputs", 32'(s), 32'(expect_vec(rdy, bt)));
    if (!rst && m_state != 0) dut_gap++;
    if (s[10]) begin
      check("retire_latency", 32'(dut_gap), 32'(m_base + m_stall));
      dut_gap = 0;
    end
    model_advance(rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(1'b1, 1'b0);
    check("reset_state", 32'(s[3:0]), 32'd0);
    check("reset_trap", 32'({s[6], s[5:4]}), 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] valid [9];
    logic [6:0] bad [4];
    int r;
    valid = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    bad = '{7'b0001111, 7'b1110011, 7'b0000000, 7'b1111111};
    r = $urandom_range(0, 19);
    if (r == 19) return bad[$urandom_range(0, 3)];
    return valid[r % 9];
  endfunction

  task automatic run_random(input int ncyc);
    int tcnt;
    tcnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (m_state == 15) tcnt++;
      if (tcnt > 3 || $urandom_range(0, 249) == 0) begin
        do_reset();
        tcnt = 0;
      end else begin
        if (m_state == 0 || (m_state == 1 && m_waits == 0)) opcode = pick_op();
        tick($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    int add_seq [4];
    logic lw_rdy [11];
    int ir_cnt, ret_idx;
    add_seq = '{1, 2, 7, 9};
    lw_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // add with memory always ready
    sel = 0;
    opcode = OP_R;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick(1'b1, 1'b0);
      check("add_state", 32'(s[3:0]), (i == 0) ? 32'd0 : 32'(add_seq[(i-1)%4]));
      check("add_reg_write", 32'(s[19]), 32'(i != 0 && (i-1)%4 == 3));
      check("add_retire", 32'(s[10]), 32'(i != 0 && (i-1)%4 == 3));
    end

    // lw with 2 fetch waits and 3 read waits
    opcode = OP_LOAD;
    do_reset();
    ir_cnt = 0;
    ret_idx = -1;
    for (int i = 0; i < 11; i++) begin
      tick(lw_rdy[i], 1'b0);
      ir_cnt += int'(s[21]);
      if (s[10] && ret_idx < 0) ret_idx = i;
      if (i >= 6 && i <= 9) check("lw_memread_hold", 32'({s[24], s[23], s[22], s[3:0]}), 32'({3'b101, 4'd4}));
      if (i >= 1 && i <= 3) check("lw_fetch_hold", 32'({s[24], s[22]}), 32'b10);
      if (i == 10) check("lw_memwb_result", 32'({s[3:0], s[14:13]}), 32'({4'd5, 2'b01}));
    end
    check("lw_ir_write_once", 32'(ir_cnt), 32'd1);
    check("lw_retire_cycle", 32'(ret_idx), 32'd10);

    // beq taken then not taken
    opcode = OP_BRANCH;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, (i <= 3) ? 1'b1 : 1'b0);
      if (i == 3) check("beq_taken", 32'({s[3:0], s[20], s[10]}), 32'({4'd10, 2'b11}));
      if (i == 6) check("beq_not_taken", 32'({s[3:0], s[20], s[10]}), 32'({4'd10, 2'b01}));
    end

    // jalr
    opcode = OP_JALR;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (i == 3) check("jalr_pc", 32'({s[3:0], s[20], s[14:13]}), 32'({4'd12, 1'b1, 2'b10}));
      if (i == 4) check("jalr_link", 32'({s[3:0], s[19], s[18:17], s[16:15]}), 32'({4'd13, 1'b1, 2'b01, 2'b10}));
    end

    // illegal opcode traps, memory stays quiet, reset recovers
    opcode = 7'b0001111;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check("illegal_trap", 32'({s[3:0], s[6], s[5:4]}), 32'({4'd15, 1'b1, 2'b01}));
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      check("trap_no_mem_req", 32'(s[24]), 32'd0);
    end
    do_reset();

    // timeout disabled: a long fetch stall still decodes
    opcode = OP_I;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("no_timeout_decode", 32'({s[3:0], s[6]}), 32'({4'd2, 1'b0}));

    // TIMEOUT_CYCLES=4: four waits trap, ready on the fourth wins
    sel = 1;
    opcode = OP_R;
    do_reset();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("timeout_trap", 32'({s[3:0], s[6], s[5:4]}), 32'({4'd15, 1'b1, 2'b10}));
    do_reset();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("timeout_ready_wins", 32'({s[3:0], s[6]}), 32'({4'd2, 1'b0}));

    // randomized traffic on both configurations
    sel = 0;
    do_reset();
    run_random(1500);
    sel = 1;
    do_reset();
    run_random(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
